// File: rtl/rst_ce_sequencer.sv
// Sequences the reset and clock-enable lines of a downstream datapath from one-cycle
// software requests, stretching reset, inserting a settle gap and gating enable.
module rst_ce_sequencer #(
    parameter int RST_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rst_req,
    input  logic             i_run_req,
    input  logic             i_halt_req,
    output logic             o_dut_rst,
    output logic             o_dut_ce,
    output logic             o_ready,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_rst_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESET  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    generate
        if (RST_CYCLES == 0 || RST_CYCLES >= 2**CNT_W || SETTLE_CYCLES >= 2**CNT_W) begin : g_badParams
            $error("rst_ce_sequencer: RST_CYCLES must be >=1 and both cycle counts must fit in CNT_W bits");
        end
    endgenerate

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;
    logic [CNT_W-1:0] r_rstCount;
    logic             w_seqDone;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= RESET;
            r_cnt      <= '0;
            r_rstCount <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            if (w_seqDone && r_rstCount != {CNT_W{1'b1}}) begin
                r_rstCount <= r_rstCount + 1'b1;
            end
        end
    end

    // A reset request restarts the count from any state; other requests only act in IDLE/RUN.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_seqDone   = 1'b0;
        if (i_rst_req) begin
            w_nextState = RESET;
            w_nextCnt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!i_halt_req && i_run_req) begin
                        w_nextState = RUN;
                    end
                end
                RESET: begin
                    if (r_cnt == RST_LAST) begin
                        w_nextCnt = '0;
                        if (SETTLE_CYCLES == 0) begin
                            w_nextState = IDLE;
                            w_seqDone   = 1'b1;
                        end else begin
                            w_nextState = SETTLE;
                        end
                    end else begin
                        w_nextCnt = r_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        w_nextCnt   = '0;
                        w_nextState = IDLE;
                        w_seqDone   = 1'b1;
                    end else begin
                        w_nextCnt = r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (i_halt_req) begin
                        w_nextState = IDLE;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_dut_rst   = (r_state == RESET);
        o_dut_ce    = (r_state == RUN);
        o_ready     = (r_state == IDLE);
        o_state     = r_state;
        o_rst_count = r_rstCount;
    end

endmodule

// File: tb/tb_rst_ce_sequencer.sv
// Directed bench for rst_ce_sequencer: a vector table for the default instance plus
// hand-written sequences for a CNT_W=2, SETTLE_CYCLES=0 instance and invariant monitors.
module tb_rst_ce_sequencer;

    typedef struct {
        logic       rst;
        logic       rstReq;
        logic       runReq;
        logic       haltReq;
        logic       expDutRst;
        logic       expDutCe;
        logic       expReady;
        logic [1:0] expState;
        logic [7:0] expCount;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Default instance
    logic       aRst = 1'b1, aRstReq = 1'b0, aRunReq = 1'b0, aHaltReq = 1'b0;
    logic       aDutRst, aDutCe, aReady;
    logic [1:0] aState;
    logic [7:0] aCount;

    rst_ce_sequencer #(.RST_CYCLES(2), .SETTLE_CYCLES(1), .CNT_W(8)) dutA (
        .i_clk(clk), .i_rst(aRst), .i_rst_req(aRstReq), .i_run_req(aRunReq),
        .i_halt_req(aHaltReq), .o_dut_rst(aDutRst), .o_dut_ce(aDutCe),
        .o_ready(aReady), .o_state(aState), .o_rst_count(aCount)
    );

    // Narrow counter, no settle phase
    logic       bRst = 1'b1, bRstReq = 1'b0, bRunReq = 1'b0, bHaltReq = 1'b0;
    logic       bDutRst, bDutCe, bReady;
    logic [1:0] bState;
    logic [1:0] bCount;

    rst_ce_sequencer #(.RST_CYCLES(2), .SETTLE_CYCLES(0), .CNT_W(2)) dutB (
        .i_clk(clk), .i_rst(bRst), .i_rst_req(bRstReq), .i_run_req(bRunReq),
        .i_halt_req(bHaltReq), .o_dut_rst(bDutRst), .o_dut_ce(bDutCe),
        .o_ready(bReady), .o_state(bState), .o_rst_count(bCount)
    );

    // Invariant monitors: rst/ce exclusivity, minimum reset width, ce rises only from IDLE
    int         violations = 0;
    int         aWidth = 0, bWidth = 0;
    logic       aPrevCe = 1'b0, bPrevCe = 1'b0;
    logic [1:0] aPrevState = 2'd1, bPrevState = 2'd1;
    int         bSettleSeen = 0;

    always @(negedge clk) begin
        if (aDutRst && aDutCe) begin
            violations++;
            $display("[TB] FAIL invA_exclusive at %0t: dut_rst=%b dut_ce=%b, required not both 1", $time, aDutRst, aDutCe);
        end
        if (aDutRst) aWidth++;
        else begin
            if (aWidth > 0 && aWidth < 2) begin
                violations++;
                $display("[TB] FAIL invA_rstWidth at %0t: pulse=%0d, required >=2", $time, aWidth);
            end
            aWidth = 0;
        end
        if (aDutCe && !aPrevCe && aPrevState != 2'd0) begin
            violations++;
            $display("[TB] FAIL invA_ceFromIdle at %0t: prev state=%0d, required 0", $time, aPrevState);
        end
        aPrevCe = aDutCe;
        aPrevState = aState;

        if (bDutRst && bDutCe) begin
            violations++;
            $display("[TB] FAIL invB_exclusive at %0t: dut_rst=%b dut_ce=%b, required not both 1", $time, bDutRst, bDutCe);
        end
        if (bDutRst) bWidth++;
        else begin
            if (bWidth > 0 && bWidth < 2) begin
                violations++;
                $display("[TB] FAIL invB_rstWidth at %0t: pulse=%0d, required >=2", $time, bWidth);
            end
            bWidth = 0;
        end
        if (bDutCe && !bPrevCe && bPrevState != 2'd0) begin
            violations++;
            $display("[TB] FAIL invB_ceFromIdle at %0t: prev state=%0d, required 0", $time, bPrevState);
        end
        if (bState == 2'd2) bSettleSeen++;
        bPrevCe = bDutCe;
        bPrevState = bState;
    end

    vec_t vecs[$];

    task automatic addVec(input logic r, input logic q, input logic u, input logic h,
                          input logic eRst, input logic eCe, input logic eRdy,
                          input logic [1:0] eSt, input logic [7:0] eCnt);
        vec_t v;
        v.rst = r; v.rstReq = q; v.runReq = u; v.haltReq = h;
        v.expDutRst = eRst; v.expDutCe = eCe; v.expReady = eRdy;
        v.expState = eSt; v.expCount = eCnt;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [12:0] actual, input logic [12:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got rst/ce/rdy/st/cnt=%b, required %b", name, actual, expected);
    endtask

    task automatic applyStimulus(input vec_t v);
        aRst = v.rst; aRstReq = v.rstReq; aRunReq = v.runReq; aHaltReq = v.haltReq;
        tick();
        aRst = 1'b0; aRstReq = 1'b0; aRunReq = 1'b0; aHaltReq = 1'b0;
    endtask

    task automatic checkB(input string name, input logic [1:0] eSt, input logic [1:0] eCnt);
        checks++;
        if (bState === eSt && bCount === eCnt) passes++;
        else $display("[TB] FAIL %s: got state=%0d count=%0d, required state=%0d count=%0d", name, bState, bCount, eSt, eCnt);
    endtask

    initial begin
        // T1: rst held 3 cycles, then 2 more reset cycles, 1 settle, idle with count 1
        //       rst q u h  dRst ce rdy st  cnt
        addVec(1, 0, 0, 0, 1, 0, 0, 2'd1, 8'd0);
        addVec(1, 0, 0, 0, 1, 0, 0, 2'd1, 8'd0);
        addVec(1, 0, 0, 0, 1, 0, 0, 2'd1, 8'd0);
        addVec(0, 0, 0, 0, 1, 0, 0, 2'd1, 8'd0);
        addVec(0, 0, 0, 0, 0, 0, 0, 2'd2, 8'd0);
        addVec(0, 0, 0, 0, 0, 0, 1, 2'd0, 8'd1);
        addVec(0, 0, 0, 0, 0, 0, 1, 2'd0, 8'd1);
        // T2: run, 4 idle-input cycles, halt on the 5th edge after run
        addVec(0, 0, 1, 0, 0, 1, 0, 2'd3, 8'd1);
        addVec(0, 0, 0, 0, 0, 1, 0, 2'd3, 8'd1);
        addVec(0, 0, 0, 0, 0, 1, 0, 2'd3, 8'd1);
        addVec(0, 0, 0, 0, 0, 1, 0, 2'd3, 8'd1);
        addVec(0, 0, 0, 0, 0, 1, 0, 2'd3, 8'd1);
        addVec(0, 0, 0, 1, 0, 0, 1, 2'd0, 8'd1);
        // T3: rst_req from RUN
        addVec(0, 0, 1, 0, 0, 1, 0, 2'd3, 8'd1);
        addVec(0, 1, 0, 0, 1, 0, 0, 2'd1, 8'd1);
        addVec(0, 0, 0, 0, 1, 0, 0, 2'd1, 8'd1);
        addVec(0, 0, 0, 0, 0, 0, 0, 2'd2, 8'd1);
        addVec(0, 0, 0, 0, 0, 0, 1, 2'd0, 8'd2);
        // T4: rst_req again on the 2nd reset cycle stretches reset to 3 cycles
        addVec(0, 1, 0, 0, 1, 0, 0, 2'd1, 8'd2);
        addVec(0, 1, 0, 0, 1, 0, 0, 2'd1, 8'd2);
        addVec(0, 0, 0, 0, 1, 0, 0, 2'd1, 8'd2);
        addVec(0, 0, 0, 0, 0, 0, 0, 2'd2, 8'd2);
        addVec(0, 0, 0, 0, 0, 0, 1, 2'd0, 8'd3);
        // T5: run+halt together, run dropped during SETTLE
        addVec(0, 0, 1, 1, 0, 0, 1, 2'd0, 8'd3);
        addVec(0, 0, 1, 0, 0, 1, 0, 2'd3, 8'd3);
        addVec(0, 0, 1, 1, 0, 0, 1, 2'd0, 8'd3);
        addVec(0, 1, 0, 0, 1, 0, 0, 2'd1, 8'd3);
        addVec(0, 0, 0, 0, 1, 0, 0, 2'd1, 8'd3);
        addVec(0, 0, 0, 0, 0, 0, 0, 2'd2, 8'd3);
        addVec(0, 0, 1, 0, 0, 0, 1, 2'd0, 8'd4);
        addVec(0, 0, 0, 0, 0, 0, 1, 2'd0, 8'd4);
        addVec(0, 0, 0, 1, 0, 0, 1, 2'd0, 8'd4);
        // Priority: rst beats halt, rst_req beats halt and run
        addVec(0, 0, 1, 0, 0, 1, 0, 2'd3, 8'd4);
        addVec(1, 0, 0, 1, 1, 0, 0, 2'd1, 8'd0);
        addVec(0, 0, 1, 0, 1, 0, 0, 2'd1, 8'd0);
        addVec(0, 0, 0, 1, 0, 0, 0, 2'd2, 8'd0);
        addVec(0, 0, 0, 0, 0, 0, 1, 2'd0, 8'd1);
        addVec(0, 0, 1, 0, 0, 1, 0, 2'd3, 8'd1);
        addVec(0, 1, 1, 1, 1, 0, 0, 2'd1, 8'd1);
        addVec(0, 0, 0, 0, 1, 0, 0, 2'd1, 8'd1);
        addVec(0, 0, 0, 0, 0, 0, 0, 2'd2, 8'd1);
        addVec(0, 0, 0, 0, 0, 0, 1, 2'd0, 8'd2);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vecA[%0d]", i),
                        {aDutRst, aDutCe, aReady, aState, aCount},
                        {vecs[i].expDutRst, vecs[i].expDutCe, vecs[i].expReady, vecs[i].expState, vecs[i].expCount});
        end

        // T6: CNT_W=2, no settle phase; reset release, then five rst_req sequences
        bRst = 1'b1;
        tick();
        checkB("B_reset", 2'd1, 2'd0);
        bRst = 1'b0;
        tick();
        checkB("B_release1", 2'd1, 2'd0);
        tick();
        checkB("B_firstIdle", 2'd0, 2'd1);
        for (int k = 0; k < 5; k++) begin
            bRstReq = 1'b1;
            tick();
            bRstReq = 1'b0;
            checkB($sformatf("B_seq%0d_rst0", k), 2'd1, (k + 1 > 3) ? 2'd3 : 2'(k + 1));
            tick();
            checkB($sformatf("B_seq%0d_rst1", k), 2'd1, (k + 1 > 3) ? 2'd3 : 2'(k + 1));
            tick();
            checkB($sformatf("B_seq%0d_idle", k), 2'd0, (k + 2 > 3) ? 2'd3 : 2'(k + 2));
        end

        checks++;
        if (bSettleSeen == 0) passes++;
        else $display("[TB] FAIL B_noSettle: settle cycles=%0d, required 0", bSettleSeen);

        tick();
        checks++;
        if (violations == 0) passes++;
        else $display("[TB] FAIL invariants: violations=%0d, required 0", violations);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
